regfile_exec_ctrl: RTL

- Initiator side of the CPU register-file port pair. Accepts one ALU instruction at a time over a valid/ready handshake.
- Drives the two read-address ports, captures the returned operands and computes a 4-bit ALU result. Drives the write port for one cycle to commit it.
- Sits between the instruction decoder and the 32x4-bit register file.

---
 rtl/regfile_exec_ctrl_pkg.sv | 26 ++
 rtl/regfile_exec_ctrl_if.sv | 48 ++++
 rtl/regfile_exec_ctrl_alu4.sv | 38 +++
 rtl/regfile_exec_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/regfile_exec_ctrl_pkg.sv
// Shared CPU definitions: ALU opcodes, controller FSM encoding and default widths.
// Imported by the register-file execute controller, its interface and alu4.
package cpu_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_PASS = 3'd6,
    ALU_SHL  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/regfile_exec_ctrl_if.sv
// Instruction handshake plus register-file read/write port bundle.
// Flag outputs exist only when REGFILE_EXEC_FLAGS_EN is defined.
interface regfile_exec_ctrl_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              write_en;
  logic              done;
  logic              busy;
`ifdef REGFILE_EXEC_FLAGS_EN
  logic              flag_z;
  logic              flag_c;
`endif

  // Controller side: accepts instructions and drives the regfile ports.
  modport master (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, rdata1, rdata2,
`ifdef REGFILE_EXEC_FLAGS_EN
    output flag_z, flag_c,
`endif
    output instr_ready, raddr1, raddr2, waddr, wdata, write_en, done, busy
  );

  // Decoder / register-file side.
  modport slave (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, rdata1, rdata2,
`ifdef REGFILE_EXEC_FLAGS_EN
    input  flag_z, flag_c,
`endif
    input  instr_ready, raddr1, raddr2, waddr, wdata, write_en, done, busy
  );

endinterface

// File: rtl/regfile_exec_ctrl_alu4.sv
// Purely combinational ALU: (op, a, b) -> (result, carry); carry is the
// ADD carry-out, SUB borrow or the bit shifted out by SHL, else 0.
module alu4
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOT:  result = ~a;
      ALU_PASS: result = a;
      ALU_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_exec_ctrl.sv
// Register-file execute controller: IDLE -> READ -> EXEC -> WB, one ALU op per 4 cycles.
// Optional Z/C flag outputs are enabled by defining REGFILE_EXEC_FLAGS_EN.
module regfile_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                 clk,
  input logic                 rst,
  regfile_exec_ctrl_if.master bus
);

  ctrl_state_e state_q, state_d;

  alu_op_e           op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] raddr1_q, raddr2_q, waddr_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, wdata_q;
  logic [DATA_W-1:0] alu_result;
  logic              ready_c, busy_c, write_en_c, done_c;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.instr_valid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs: reset forcing state to IDLE drops write_en/done asynchronously.
  always_comb begin
    ready_c    = 1'b0;
    busy_c     = 1'b1;
    write_en_c = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        busy_c  = 1'b0;
      end
      ST_WB: begin
        write_en_c = 1'b1;
        done_c     = 1'b1;
      end
      default: ;
    endcase
  end

  `ifdef REGFILE_EXEC_FLAGS_EN
  logic alu_carry, carry_q;
  `else
  logic unused_carry;
  `endif

  alu4 #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .result (alu_result),
`ifdef REGFILE_EXEC_FLAGS_EN
    .carry  (alu_carry)
`else
    .carry  (unused_carry)
`endif
  );

  // Read addresses double as the rs1/rs2 latches; they hold outside READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= ALU_ADD;
      rd_q     <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.instr_valid) begin
          op_q     <= alu_op_e'(bus.instr_op);
          rd_q     <= bus.instr_rd;
          raddr1_q <= bus.instr_rs1;
          raddr2_q <= bus.instr_rs2;
        end
        ST_READ: begin
          op_a_q <= bus.rdata1;
          op_b_q <= bus.rdata2;
        end
        ST_EXEC: begin
          wdata_q <= alu_result;
          waddr_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

`ifdef REGFILE_EXEC_FLAGS_EN
  logic flag_z_q, flag_c_q;

  // Carry is captured alongside wdata; both flags become visible after the WB edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      if (state_q == ST_EXEC) carry_q <= alu_carry;
      if (state_q == ST_WB) begin
        flag_z_q <= (wdata_q == '0);
        flag_c_q <= carry_q;
      end
    end
  end

  assign bus.flag_z = flag_z_q;
  assign bus.flag_c = flag_c_q;
`endif

  assign bus.instr_ready = ready_c;
  assign bus.busy        = busy_c;
  assign bus.write_en    = write_en_c;
  assign bus.done        = done_c;
  assign bus.raddr1      = raddr1_q;
  assign bus.raddr2      = raddr2_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;

endmodule
